// File: rtl/conv_seq_pkg.sv
// Shared types and constants for the 3x3 convolution sequencer: state encoding,
// convolutor operation codes and configuration limits.
package conv_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PAD_TOP,
    BODY,
    PAD_BOT,
    FLUSH,
    DRAIN,
    DONE
  } state_e;

  localparam logic [1:0] OP_CONV3X3 = 2'd0;
  localparam logic [1:0] OP_IDLE    = 2'd1;

  localparam int CFG_W      = 8;
  localparam int CNT_W      = 16;
  localparam int MIN_WIDTH  = 3;
  localparam int MIN_HEIGHT = 1;

  function automatic logic cfg_in_range(input logic [CFG_W-1:0] v, input int lo, input int hi);
    return (int'(v) >= lo) && (int'(v) <= hi);
  endfunction

endpackage

// File: rtl/seq_tag_delay.sv
// Fixed-depth shift register that carries per-issue tags alongside the datapath
// latency; clr empties every stage so nothing in flight survives a cancel.
module seq_tag_delay #(
  parameter int TAG_W = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [TAG_W-1:0] tag_i,
  output logic [TAG_W-1:0] tag_o
);

  logic [TAG_W-1:0] stage_q [0:DEPTH-1];
  logic [TAG_W-1:0] stage_d [0:DEPTH-1];

  always_comb begin
    for (int i = 0; i < DEPTH; i++) stage_d[i] = '0;
    if (!clr) begin
      stage_d[0] = tag_i;
      for (int i = 1; i < DEPTH; i++) stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign tag_o = stage_q[DEPTH-1];

endmodule

// File: rtl/conv3x3_sequencer.sv
// Streams one feature-map channel, framed by zero rows and a flush pixel, into a
// 3x3 convolutor and tags each valid result with its row and column.
module conv3x3_sequencer
  import conv_seq_pkg::*;
#(
  parameter int IMAGE_WIDTH  = 128,
  parameter int IMAGE_HEIGHT = 128,
  parameter int ADDR_W       = 14,
  parameter int RD_LAT       = 1,
  parameter int PIPE_LAT     = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    abort,
  input  logic [7:0]              cfg_width,
  input  logic [7:0]              cfg_height,
  input  logic                    cfg_relu,
  output logic                    mem_rd_en,
  output logic [ADDR_W-1:0]       mem_addr,
  input  logic signed [7:0]       mem_rdata,
  output logic signed [7:0]       conv_pixel_in,
  output logic [1:0]              conv_operation,
  output logic                    conv_paddingl,
  output logic                    conv_paddingr,
  output logic                    conv_relu,
  output logic                    out_valid,
  output logic [7:0]              out_row,
  output logic [7:0]              out_col,
  output logic                    busy,
  output logic                    done,
  output logic                    cfg_err
);

  localparam int OUT_LAT = RD_LAT + PIPE_LAT;
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(OUT_LAT - 1);

  state_e                 state_q, state_d;
  logic [CFG_W-1:0]       w_q, w_d;
  logic [CFG_W-1:0]       row_q, row_d, col_q, col_d;
  logic                   relu_q, relu_d;
  logic                   cfg_err_q, cfg_err_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0]       k_q, k_d;
  logic [CNT_W-1:0]       hw_q, hw_d;
  logic [CNT_W-1:0]       thr_q, thr_d;
  logic [CNT_W-1:0]       w_ext;
  logic                   cfg_ok, issuing, res_issue, body_issue, body_dly;
  logic [2*CFG_W:0]       res_tag_i, res_tag_o;

  assign w_ext      = CNT_W'(w_q);
  assign cfg_ok     = cfg_in_range(cfg_width, MIN_WIDTH, IMAGE_WIDTH) &&
                      cfg_in_range(cfg_height, MIN_HEIGHT, IMAGE_HEIGHT);
  assign issuing    = state_q inside {PAD_TOP, BODY, PAD_BOT, FLUSH};
  assign body_issue = (state_q == BODY);
  // Padded index k yields a result once the window centre has moved past the top pad row.
  assign res_issue  = issuing && (k_q >= thr_q);

  always_comb begin
    state_d   = state_q;
    w_d       = w_q;
    relu_d    = relu_q;
    hw_d      = hw_q;
    thr_d     = thr_q;
    row_d     = row_q;
    col_d     = col_q;
    cfg_err_d = 1'b0;
    cnt_d     = cnt_q + CNT_ONE;
    k_d       = issuing ? k_q + CNT_ONE : k_q;

    if (res_issue) begin
      if (col_q == w_q - 8'd1) begin
        col_d = '0;
        row_d = row_q + 8'd1;
      end else begin
        col_d = col_q + 8'd1;
      end
    end

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (start && !abort) begin
          if (cfg_ok) begin
            state_d = PAD_TOP;
            w_d     = cfg_width;
            relu_d  = cfg_relu;
            hw_d    = CNT_W'(cfg_width) * CNT_W'(cfg_height);
            thr_d   = (CNT_W'(cfg_width) << 1) + CNT_ONE;
            k_d     = '0;
            row_d   = '0;
            col_d   = '0;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      PAD_TOP: if (cnt_q == w_ext - CNT_ONE) begin state_d = BODY;    cnt_d = '0; end
      BODY:    if (cnt_q == hw_q - CNT_ONE)  begin state_d = PAD_BOT; cnt_d = '0; end
      PAD_BOT: if (cnt_q == w_ext - CNT_ONE) begin state_d = FLUSH;   cnt_d = '0; end
      FLUSH: begin
        state_d = DRAIN;
        cnt_d   = '0;
      end
      DRAIN:   if (cnt_q == DRAIN_LAST) state_d = DONE;
      DONE: begin
        state_d = IDLE;
        relu_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase

    if (abort && state_q != IDLE) begin
      state_d = IDLE;
      relu_d  = 1'b0;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      w_q       <= '0;
      relu_q    <= 1'b0;
      hw_q      <= '0;
      thr_q     <= '0;
      row_q     <= '0;
      col_q     <= '0;
      cfg_err_q <= 1'b0;
      cnt_q     <= '0;
      k_q       <= '0;
    end else begin
      state_q   <= state_d;
      w_q       <= w_d;
      relu_q    <= relu_d;
      hw_q      <= hw_d;
      thr_q     <= thr_d;
      row_q     <= row_d;
      col_q     <= col_d;
      cfg_err_q <= cfg_err_d;
      cnt_q     <= cnt_d;
      k_q       <= k_d;
    end
  end

  // Body flag lines up with returning read data; result tags also cover the convolutor pipe.
  seq_tag_delay #(.TAG_W(1), .DEPTH(RD_LAT)) u_body_dly (
    .clk   (clk),
    .rst   (rst),
    .clr   (abort && busy),
    .tag_i (body_issue),
    .tag_o (body_dly)
  );

  assign res_tag_i = res_issue ? {1'b1, row_q, col_q} : '0;

  seq_tag_delay #(.TAG_W(2*CFG_W+1), .DEPTH(OUT_LAT)) u_res_dly (
    .clk   (clk),
    .rst   (rst),
    .clr   (abort && busy),
    .tag_i (res_tag_i),
    .tag_o (res_tag_o)
  );

  assign {out_valid, out_row, out_col} = res_tag_o;

  assign busy           = (state_q != IDLE);
  assign done           = (state_q == DONE);
  assign cfg_err        = cfg_err_q;
  assign mem_rd_en      = body_issue;
  assign mem_addr       = body_issue ? ADDR_W'(cnt_q) : '0;
  assign conv_pixel_in  = body_dly ? mem_rdata : '0;
  assign conv_operation = (state_q inside {PAD_TOP, BODY, PAD_BOT, FLUSH, DRAIN}) ? OP_CONV3X3 : OP_IDLE;
  assign conv_paddingl  = out_valid && (out_col == 8'd0);
  assign conv_paddingr  = out_valid && (out_col == w_q - 8'd1);
  assign conv_relu      = relu_q;

endmodule

// File: tb/tb_conv3x3_sequencer.sv
// Bench for conv3x3_sequencer: frame-memory model, index-arithmetic reference of every
// output per cycle, and a window-sum convolutor compared against a direct 3x3 convolution.
module tb_conv3x3_sequencer;

  localparam int RD_LAT   = 1;
  localparam int PIPE_LAT = 1;
  localparam int L        = RD_LAT + PIPE_LAT;
  localparam int ADDR_W   = 14;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0, abort = 1'b0;
  logic [7:0]        cfg_width = 8'd0, cfg_height = 8'd0;
  logic              cfg_relu = 1'b0;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic signed [7:0] mem_rdata = 8'sd0;
  logic signed [7:0] conv_pixel_in;
  logic [1:0]        conv_operation;
  logic              conv_paddingl, conv_paddingr, conv_relu;
  logic              out_valid;
  logic [7:0]        out_row, out_col;
  logic              busy, done, cfg_err;

  conv3x3_sequencer #(
    .IMAGE_WIDTH(128), .IMAGE_HEIGHT(128), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT), .PIPE_LAT(PIPE_LAT)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .cfg_width(cfg_width), .cfg_height(cfg_height), .cfg_relu(cfg_relu),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .conv_pixel_in(conv_pixel_in), .conv_operation(conv_operation),
    .conv_paddingl(conv_paddingl), .conv_paddingr(conv_paddingr), .conv_relu(conv_relu),
    .out_valid(out_valid), .out_row(out_row), .out_col(out_col),
    .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0, n_err = 0;
  logic signed [7:0] mem [0:(1<<ADDR_W)-1];

  // Reference model state for the pass in flight.
  bit m_act = 0;
  int m_s = 0, m_w = 0, m_h = 0, m_abort = -1, m_err_t = -1;
  bit m_relu = 0;
  bit chk_en = 0;

  // Observations gathered during a pass.
  int nvalid, first_v, n_done, done_t, nrd, max_addr;
  int pix_hist[int];
  int conv_res[int];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s t=%0d got=%0d want=%0d", name, cyc, act, exp);
    end
  endtask

  function automatic int ref_conv(input int r, input int c);
    int s = 0;
    for (int dr = -1; dr <= 1; dr++)
      for (int dc = -1; dc <= 1; dc++)
        if (r+dr >= 0 && r+dr < m_h && c+dc >= 0 && c+dc < m_w)
          s += int'(mem[(r+dr)*m_w + (c+dc)]);
    if (m_relu && s < 0) s = 0;
    return s;
  endfunction

  // Synchronous-read frame memory; undriven cycles return junk so the zero gating is exercised.
  bit pend_en = 0;
  int pend_addr = 0;
  always @(negedge clk) begin
    pend_en   = mem_rd_en;
    pend_addr = int'(mem_addr);
  end
  always @(posedge clk) begin
    if (pend_en) mem_rdata = mem[pend_addr];
    else         mem_rdata = 8'($urandom);
  end

  always @(negedge clk) begin
    if (chk_en) begin
      int d, n, k, ki, ko, j, sum, m, idx;
      int e_busy, e_done, e_rd, e_addr, e_pix, e_op, e_v, e_row, e_col, e_pl, e_pr, e_relu, e_err;
      e_busy = 0; e_done = 0; e_rd = 0; e_addr = 0; e_pix = 0; e_op = 1;
      e_v = 0; e_row = 0; e_col = 0; e_pl = 0; e_pr = 0; e_relu = 0;
      e_err = (cyc == m_err_t) ? 1 : 0;
      ko = 0;
      if (m_act && !(m_abort >= 0 && cyc > m_abort)) begin
        d  = cyc - m_s;
        n  = (m_h + 2) * m_w;
        if (d >= 1 && d <= n + 2 + L) begin e_busy = 1; e_relu = m_relu; end
        if (d == n + 2 + L) e_done = 1;
        if (d >= 1 && d <= n + 1 + L) e_op = 0;
        k = d - 1;
        if (k >= m_w && k < m_w + m_w*m_h) begin e_rd = 1; e_addr = k - m_w; end
        ki = d - 1 - RD_LAT;
        if (ki >= m_w && ki < m_w + m_w*m_h) e_pix = int'(mem[ki - m_w]);
        ko = d - 1 - L;
        if (ko >= 2*m_w + 1 && ko <= n) begin
          j = ko - (2*m_w + 1);
          e_v = 1; e_row = j / m_w; e_col = j % m_w;
          e_pl = (e_col == 0); e_pr = (e_col == m_w - 1);
        end
      end
      check("busy", busy, e_busy);
      check("done", done, e_done);
      check("cfg_err", cfg_err, e_err);
      check("mem_rd_en", mem_rd_en, e_rd);
      check("mem_addr", int'(mem_addr), e_addr);
      check("pixel_in", int'(conv_pixel_in), e_pix);
      check("operation", int'(conv_operation), e_op);
      check("relu", conv_relu, e_relu);
      check("out_valid", out_valid, e_v);
      check("out_row", int'(out_row), e_row);
      check("out_col", int'(out_col), e_col);
      check("paddingl", conv_paddingl, e_pl);
      check("paddingr", conv_paddingr, e_pr);
      // Convolutor stand-in: window of the received stream centred W+1 samples behind.
      if (out_valid && e_v) begin
        sum = 0;
        m = ko - m_w - 1;
        for (int dr = -1; dr <= 1; dr++)
          for (int dc = -1; dc <= 1; dc++) begin
            if ((dc == -1 && conv_paddingl) || (dc == 1 && conv_paddingr)) continue;
            idx = m + dr*m_w + dc;
            if (idx >= 0 && pix_hist.exists(m_s + 1 + idx + RD_LAT))
              sum += pix_hist[m_s + 1 + idx + RD_LAT];
          end
        if (conv_relu && sum < 0) sum = 0;
        check("conv_result", sum, ref_conv(e_row, e_col));
        conv_res[e_row*16 + e_col] = sum;
      end
      pix_hist[cyc] = int'(conv_pixel_in);
      if (out_valid) begin nvalid++; if (first_v < 0) first_v = cyc - m_s; end
      if (done) begin n_done++; done_t = cyc - m_s; end
      if (mem_rd_en) begin nrd++; if (int'(mem_addr) > max_addr) max_addr = int'(mem_addr); end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic fill(input int v);
    for (int i = 0; i < 256; i++) mem[i] = 8'(v);
  endtask

  task automatic fill_rand();
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
  endtask

  task automatic start_pass(input int w, input int h, input bit relu);
    cfg_width = 8'(w); cfg_height = 8'(h); cfg_relu = relu; start = 1'b1;
    m_act = 1; m_s = cyc; m_w = w; m_h = h; m_relu = relu; m_abort = -1;
    nvalid = 0; first_v = -1; n_done = 0; done_t = -1; nrd = 0; max_addr = -1;
    pix_hist.delete(); conv_res.delete();
    tick(1);
    start = 1'b0;
  endtask

  task automatic finish_pass();
    tick((m_h + 2) * m_w + 1 + L + 3);
  endtask

  task automatic reject(input int w, input int h);
    cfg_width = 8'(w); cfg_height = 8'(h); start = 1'b1;
    m_err_t = cyc + 1;
    tick(1);
    start = 1'b0;
    check("cfg_err_pulse", cfg_err, 1);
    check("cfg_err_busy", busy, 0);
    tick(3);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog t=%0d got=timeout want=finish", cyc);
    $fatal(1);
  end

  initial begin
    chk_en = 1;
    #2;
    check("rst_operation", int'(conv_operation), 1);
    check("rst_busy", busy, 0);
    check("rst_out_valid", out_valid, 0);
    tick(2);
    rst = 1'b0;
    tick(2);

    // All ones, 4x4: timing and border sums.
    fill(1);
    start_pass(4, 4, 0);
    finish_pass();
    check("first_valid_cycle", first_v, 12);
    check("done_cycle", done_t, 28);
    check("valid_count_4x4", nvalid, 16);
    check("done_count", n_done, 1);
    check("corner_sum", conv_res[0], 4);
    check("edge_sum", conv_res[1], 6);
    check("interior_sum", conv_res[16 + 1], 9);

    // 5x3 random data: read range.
    fill_rand();
    start_pass(5, 3, 0);
    finish_pass();
    check("reads_5x3", nrd, 15);
    check("max_addr_5x3", max_addr, 14);
    check("valid_count_5x3", nvalid, 15);

    // All -1 with and without ReLU.
    fill(-1);
    start_pass(4, 4, 1);
    finish_pass();
    check("relu_corner", conv_res[0], 0);
    check("relu_interior", conv_res[16 + 1], 0);
    start_pass(4, 4, 0);
    finish_pass();
    check("neg_corner", conv_res[0], -4);
    check("neg_interior", conv_res[16 + 1], -9);

    // Abort partway through, then a clean pass.
    fill(1);
    start_pass(4, 4, 0);
    tick(9);
    abort = 1'b1;
    m_abort = cyc;
    tick(1);
    abort = 1'b0;
    check("abort_busy", busy, 0);
    tick(25);
    check("abort_no_done", n_done, 0);
    check("abort_no_valid", nvalid, 0);
    start_pass(4, 4, 0);
    finish_pass();
    check("after_abort_valid", nvalid, 16);
    check("after_abort_done", n_done, 1);

    // Rejected configurations and simultaneous start/abort.
    reject(2, 4);
    reject(4, 0);
    reject(129, 4);
    cfg_width = 8'd4; cfg_height = 8'd4; start = 1'b1; abort = 1'b1;
    tick(1);
    start = 1'b0; abort = 1'b0;
    check("start_abort_idle", busy, 0);
    tick(2);

    // Single-row map.
    fill_rand();
    start_pass(3, 1, 0);
    finish_pass();
    check("valid_count_h1", nvalid, 3);

    // Start during a pass must be ignored.
    start_pass(4, 3, 0);
    tick(6);
    cfg_width = 8'd2; start = 1'b1;
    tick(1);
    start = 1'b0;
    tick((m_h + 2) * m_w + L + 3 - 7);
    check("busy_start_valid", nvalid, 12);

    // Asynchronous reset in the middle of the body.
    start_pass(4, 4, 1);
    tick(8);
    #2;
    rst = 1'b1;
    m_act = 0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_operation", int'(conv_operation), 1);
    check("midrst_rd_en", mem_rd_en, 0);
    check("midrst_relu", conv_relu, 0);
    tick(2);
    rst = 1'b0;
    tick(2);

    // Randomised passes.
    for (int p = 0; p < 6; p++) begin
      fill_rand();
      start_pass(int'($urandom_range(3, 10)), int'($urandom_range(1, 6)), 1'($urandom_range(0, 1)));
      finish_pass();
      check("rand_valid_count", nvalid, m_w * m_h);
      check("rand_done_count", n_done, 1);
    end

    chk_en = 0;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
